// File: rtl/axis_tag_fanout_buffered.sv
// Tag stream fanout to FANOUT consumers, each with its own FWFT FIFO, channel filter and lossy/lossless mode.
// Optional per-output drop counters are built when TAG_FANOUT_DROP_COUNTER_EN is defined.

module axis_tag_fanout_buffered_lane #(
  parameter int WORD_WIDTH    = 4,
  parameter int TIME_WIDTH    = 64,
  parameter int CHANNEL_WIDTH = 6,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                accept,
  input  logic                                enable,
  input  logic [2**CHANNEL_WIDTH-1:0]         chan_mask,
  input  logic [WORD_WIDTH-1:0]               s_tkeep,
  input  logic [WORD_WIDTH*TIME_WIDTH-1:0]    s_tagtime,
  input  logic [WORD_WIDTH*CHANNEL_WIDTH-1:0] s_channel,
  input  logic [TIME_WIDTH-1:0]               s_lowest_time_bound,
  input  logic                                clear_counts,
  output logic                                full,
  output logic                                m_tvalid,
  input  logic                                m_tready,
  output logic [WORD_WIDTH-1:0]               m_tkeep,
  output logic [WORD_WIDTH*TIME_WIDTH-1:0]    m_tagtime,
  output logic [WORD_WIDTH*CHANNEL_WIDTH-1:0] m_channel,
  output logic [TIME_WIDTH-1:0]               m_lowest_time_bound,
  output logic [31:0]                         drop_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = WORD_WIDTH*(1+TIME_WIDTH+CHANNEL_WIDTH) + TIME_WIDTH;
  localparam logic [AW:0] DEPTH_V = (AW+1)'(FIFO_DEPTH);

  logic [WORD_WIDTH-1:0] fk;
  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic                  wr_req, push, pop, drop_inc;

  always_comb begin
    fk = '0;
    for (int i = 0; i < WORD_WIDTH; i++)
      fk[i] = s_tkeep[i] & chan_mask[s_channel[i*CHANNEL_WIDTH +: CHANNEL_WIDTH]];
  end

  // full is a registered view of occupancy, so a same-cycle pop never frees a slot for this beat
  assign wr_req   = accept & enable & (|fk);
  assign push     = wr_req & ~full;
  assign drop_inc = wr_req & full;
  assign m_tvalid = wr_ptr != rd_ptr;
  assign pop      = m_tvalid & m_tready;
  assign wr_nxt   = wr_ptr + {{AW{1'b0}}, push};
  assign rd_nxt   = rd_ptr + {{AW{1'b0}}, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      full   <= (wr_nxt - rd_nxt) == DEPTH_V;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {fk, s_channel, s_tagtime, s_lowest_time_bound};
  end

  assign {m_tkeep, m_channel, m_tagtime, m_lowest_time_bound} = mem[rd_ptr[AW-1:0]];

`ifdef TAG_FANOUT_DROP_COUNTER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           drop_count <= '0;
    else if (clear_counts)                drop_count <= '0;
    else if (drop_inc && drop_count != '1) drop_count <= drop_count + 32'd1;
  end
`else
  logic unused_cnt;
  assign unused_cnt = clear_counts ^ drop_inc;
  assign drop_count = '0;
`endif
endmodule

module axis_tag_fanout_buffered #(
  parameter int FANOUT        = 4,
  parameter int WORD_WIDTH    = 4,
  parameter int TIME_WIDTH    = 64,
  parameter int CHANNEL_WIDTH = 6,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       s_tvalid,
  output logic                                       s_tready,
  input  logic [WORD_WIDTH-1:0]                      s_tkeep,
  input  logic [WORD_WIDTH*TIME_WIDTH-1:0]           s_tagtime,
  input  logic [WORD_WIDTH*CHANNEL_WIDTH-1:0]        s_channel,
  input  logic [TIME_WIDTH-1:0]                      s_lowest_time_bound,
  output logic [FANOUT-1:0]                          m_tvalid,
  input  logic [FANOUT-1:0]                          m_tready,
  output logic [FANOUT*WORD_WIDTH-1:0]               m_tkeep,
  output logic [FANOUT*WORD_WIDTH*TIME_WIDTH-1:0]    m_tagtime,
  output logic [FANOUT*WORD_WIDTH*CHANNEL_WIDTH-1:0] m_channel,
  output logic [FANOUT*TIME_WIDTH-1:0]               m_lowest_time_bound,
  input  logic [FANOUT-1:0]                          cfg_enable,
  input  logic [FANOUT-1:0]                          cfg_lossy,
  input  logic [FANOUT*(2**CHANNEL_WIDTH)-1:0]       cfg_chan_mask,
  input  logic                                       clear_counts,
  output logic [FANOUT*32-1:0]                       drop_count
);
  logic [FANOUT-1:0] full, ok;
  logic              run_q, accept;

  // holds s_tready low until the first clock after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  assign ok       = ~cfg_enable | cfg_lossy | ~full;
  assign s_tready = run_q & (&ok);
  assign accept   = s_tvalid & s_tready;

  axis_tag_fanout_buffered_lane #(
    .WORD_WIDTH(WORD_WIDTH), .TIME_WIDTH(TIME_WIDTH),
    .CHANNEL_WIDTH(CHANNEL_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
  ) u_lane [FANOUT-1:0] (
    .clk                 (clk),
    .rst_n               (rst_n),
    .accept              (accept),
    .enable              (cfg_enable),
    .chan_mask           (cfg_chan_mask),
    .s_tkeep             (s_tkeep),
    .s_tagtime           (s_tagtime),
    .s_channel           (s_channel),
    .s_lowest_time_bound (s_lowest_time_bound),
    .clear_counts        (clear_counts),
    .full                (full),
    .m_tvalid            (m_tvalid),
    .m_tready            (m_tready),
    .m_tkeep             (m_tkeep),
    .m_tagtime           (m_tagtime),
    .m_channel           (m_channel),
    .m_lowest_time_bound (m_lowest_time_bound),
    .drop_count          (drop_count)
  );
endmodule
